srl_fifo_ctrl: RTL and testbench
================================

SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 1, payload width in bits.
REQ-002 Parameter ADDR_WIDTH, default 1, storage address width; DEPTH <= 2**ADDR_WIDTH.
REQ-003 Parameter DEPTH, default 2, storage entries, DEPTH >= 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_write  input  1  producer write request.
REQ-007 if_write_ce  input  1  producer clock enable; a write counts only with if_write=1.
REQ-008 if_din  input  DATA_WIDTH  producer payload.
REQ-009 if_full_n  output  1  registered; 1 = space available.
REQ-010 if_read  input  1  consumer read request.
REQ-011 if_read_ce  input  1  consumer clock enable; a read counts only with if_read=1.
REQ-012 if_dout  output  DATA_WIDTH  head-of-queue payload, combinational from shiftReg_dout.
REQ-013 if_empty_n  output  1  registered; 1 = if_dout valid.
REQ-014 shiftReg_we  output  1  storage shift-in enable.
REQ-015 shiftReg_addr  output  ADDR_WIDTH  storage read address.
REQ-016 shiftReg_din  output  DATA_WIDTH  storage write data, equal to if_din.
REQ-017 shiftReg_dout  input  DATA_WIDTH  storage read data at shiftReg_addr, zero latency.
REQ-018 err_sticky  output  1  protocol-error flag (see Configuration).

Function
REQ-019 push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n.
REQ-020 shiftReg_we SHALL equal push, combinationally, in the same cycle.
REQ-021 Internal count SHALL span 0..DEPTH, width ceil(log2(DEPTH+1)) bits.
REQ-022 Next count: push only +1; pop only -1; both or neither unchanged.
REQ-023 shiftReg_addr SHALL be count-1 (truncated to ADDR_WIDTH) when count>0, else 0.
REQ-024 State machine SHALL have states EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
REQ-025 Transitions: EMPTY->PARTIAL on push (DEPTH>1); PARTIAL->FULL on push-only reaching DEPTH; FULL->PARTIAL on pop-only; PARTIAL->EMPTY on pop-only reaching 0.
REQ-026 With DEPTH=1, EMPTY->FULL on push and FULL->EMPTY on pop directly.
REQ-027 if_empty_n and if_full_n SHALL be registered from next count: if_empty_n=(next!=0), if_full_n=(next!=DEPTH).
REQ-028 Write-to-read latency SHALL be 1 cycle: pushed word visible on if_dout with if_empty_n=1 in the next cycle.
REQ-029 Simultaneous push and pop in FULL SHALL be impossible: if_full_n=0 blocks push; the pop proceeds alone.
REQ-030 Simultaneous push and pop in EMPTY SHALL be impossible: if_empty_n=0 blocks pop; the push proceeds alone.
REQ-031 Simultaneous push and pop in PARTIAL SHALL leave count and flags unchanged and advance the head by one word.
REQ-032 Words SHALL emerge in strict write order; no loss and no duplication.
REQ-033 Requests while blocked (write when full, read when empty) SHALL be ignored, with no state change.

Reset
REQ-034 On reset=1 at a clock edge: count=0, state EMPTY, if_empty_n=0, if_full_n=1, err_sticky=0.
REQ-035 Reset mid-operation SHALL discard all queued words; storage contents are don't-care, never re-exposed.
REQ-036 Push and pop SHALL be suppressed in any cycle with reset=1 (shiftReg_we=0).

Configuration
REQ-037 Macro SRL_FIFO_CTRL_ERR_CHECK_EN defined: err_sticky SHALL set one cycle after any cycle with (if_write & if_write_ce & ~if_full_n) or (if_read & if_read_ce & ~if_empty_n), holding until reset.
REQ-038 Macro undefined: err_sticky SHALL be constant 0 and no detection logic SHALL be built; all other behaviour is identical.

Verification
REQ-039 DEPTH=2, DATA_WIDTH=8: reset, then push 0x11 -> next cycle if_empty_n=1, if_dout=0x11, if_full_n=1, shiftReg_addr=0.
REQ-040 Push 0x11, 0x22 back-to-back -> if_full_n=0 after second; pops return 0x11 then 0x22; then if_empty_n=0, if_full_n=1.
REQ-041 Count=1 holding 0x11, push 0x33 and pop in same cycle -> count stays 1, if_dout=0x33, flags unchanged.
REQ-042 Full, drive write 0x44 -> ignored, next pops yield prior data only; with SRL_FIFO_CTRL_ERR_CHECK_EN err_sticky=1 next cycle, else 0.
REQ-043 Full FIFO, assert reset one cycle -> if_empty_n=0, if_full_n=1, err_sticky=0; subsequent push 0x55 reads back 0x55.
REQ-044 DEPTH=1: push 0xAA -> if_full_n=0, if_empty_n=1; pop -> if_full_n=1, if_empty_n=0.

Source files
------------

// File: rtl/srl_fifo_ctrl.sv
// Control for a FIFO built on an external shift-register (SRL) storage.
// Optional protocol-error detection is enabled by defining SRL_FIFO_CTRL_ERR_CHECK_EN.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  shiftReg_we,
    output logic [ADDR_WIDTH-1:0] shiftReg_addr,
    output logic [DATA_WIDTH-1:0] shiftReg_din,
    input  logic [DATA_WIDTH-1:0] shiftReg_dout,
    output logic                  err_sticky
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt, count_m1;
    logic          push, pop;

    // Reset suppresses both sides so nothing shifts into storage during reset.
    assign push = if_write & if_write_ce & if_full_n  & ~reset;
    assign pop  = if_read  & if_read_ce  & if_empty_n & ~reset;

    assign shiftReg_we  = push;
    assign shiftReg_din = if_din;
    assign if_dout      = shiftReg_dout;

    // Newest word sits at address 0, so the head is at count-1.
    assign count_m1      = count - CW'(1);
    assign shiftReg_addr = (count == '0) ? '0 : ADDR_WIDTH'(count_m1);

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (push)
                    state_nxt = (DEPTH == 1) ? FULL : PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && count == CW'(DEPTH - 1))
                    state_nxt = FULL;
                else if (pop && !push && count == CW'(1))
                    state_nxt = EMPTY;
            end
            FULL: begin
                if (pop)
                    state_nxt = (DEPTH == 1) ? EMPTY : PARTIAL;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            count      <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            if_empty_n <= (state_nxt != EMPTY);
            if_full_n  <= (state_nxt != FULL);
        end
    end

`ifdef SRL_FIFO_CTRL_ERR_CHECK_EN
    logic bad_req;

    assign bad_req = (if_write & if_write_ce & ~if_full_n) |
                     (if_read  & if_read_ce  & ~if_empty_n);

    always_ff @(posedge clk) begin
        if (reset)
            err_sticky <= 1'b0;
        else if (bad_req)
            err_sticky <= 1'b1;
    end
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed scoreboard bench for srl_fifo_ctrl: DEPTH=2 and DEPTH=1 instances with SRL storage models.
module tb_srl_fifo_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- DEPTH=2 instance ----------------
    logic          rst, wr, wce, rd, rce;
    logic [DW-1:0] din, dout, sr_din, sr_dout;
    logic          full_n, empty_n, we, err;
    logic [0:0]    addr;
    logic [DW-1:0] mem2 [0:1];

    srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
        .clk(clk), .reset(rst),
        .if_write(wr), .if_write_ce(wce), .if_din(din), .if_full_n(full_n),
        .if_read(rd), .if_read_ce(rce), .if_dout(dout), .if_empty_n(empty_n),
        .shiftReg_we(we), .shiftReg_addr(addr), .shiftReg_din(sr_din),
        .shiftReg_dout(sr_dout), .err_sticky(err)
    );

    always @(posedge clk) if (we) begin mem2[1] <= mem2[0]; mem2[0] <= sr_din; end
    assign sr_dout = mem2[addr];

    // ---------------- DEPTH=1 instance ----------------
    logic          rst1, wr1, rd1;
    logic [DW-1:0] din1, dout1, sr_din1, sr_dout1;
    logic          full_n1, empty_n1, we1, err1;
    logic [0:0]    addr1;
    logic [DW-1:0] mem1 [0:1];

    srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .reset(rst1),
        .if_write(wr1), .if_write_ce(1'b1), .if_din(din1), .if_full_n(full_n1),
        .if_read(rd1), .if_read_ce(1'b1), .if_dout(dout1), .if_empty_n(empty_n1),
        .shiftReg_we(we1), .shiftReg_addr(addr1), .shiftReg_din(sr_din1),
        .shiftReg_dout(sr_dout1), .err_sticky(err1)
    );

    always @(posedge clk) if (we1) begin mem1[1] <= mem1[0]; mem1[0] <= sr_din1; end
    assign sr_dout1 = mem1[addr1];

    // ---------------- scoreboard ----------------
    logic [DW-1:0] q [$];
    int            mcnt;
    logic          err_exp;

`ifdef SRL_FIFO_CTRL_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic on the DEPTH=2 instance, with checks before and after the edge.
    task automatic cyc(input bit w, input bit wc, input bit r, input bit rc, input logic [DW-1:0] d);
        bit p, o;
        logic [DW-1:0] e;
        wr = w; wce = wc; rd = r; rce = rc; din = d;
        p = w && wc && (mcnt != 2);
        o = r && rc && (mcnt != 0);
        #1;
        chk("shiftReg_we", 32'(we), 32'(p));
        if (o) begin
            e = q.pop_front();
            chk("pop_data", 32'(dout), 32'(e));
        end
        if (p) q.push_back(d);
        if (ERR_EN && ((w && wc && !p) || (r && rc && !o))) err_exp = 1'b1;
        @(posedge clk); #1;
        wr = 0; rd = 0;
        mcnt = mcnt + int'(p) - int'(o);
        chk("empty_n", 32'(empty_n), 32'(mcnt != 0));
        chk("full_n", 32'(full_n), 32'(mcnt != 2));
        chk("addr", 32'(addr), (mcnt > 0) ? 32'(mcnt - 1) : 32'd0);
        chk("err_sticky", 32'(err), 32'(err_exp));
        if (mcnt > 0) chk("head", 32'(dout), 32'(q[0]));
    endtask

    task automatic do_reset();
        rst = 1; wr = 1; wce = 1; din = 8'hEE;
        #1;
        chk("we_in_reset", 32'(we), 32'd0);
        @(posedge clk); #1;
        rst = 0; wr = 0;
        q.delete(); mcnt = 0; err_exp = 1'b0;
        chk("rst_empty_n", 32'(empty_n), 32'd0);
        chk("rst_full_n", 32'(full_n), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1; wr = 0; wce = 1; rd = 0; rce = 1; din = '0;
        rst1 = 1; wr1 = 0; rd1 = 0; din1 = '0;
        mcnt = 0; err_exp = 1'b0;
        @(posedge clk); #1;
        rst1 = 0;
        do_reset();

        // single push, 1-cycle latency
        cyc(1, 1, 0, 1, 8'h11);
        // second push fills, then drain in order
        cyc(1, 1, 0, 1, 8'h22);
        cyc(0, 1, 1, 1, 8'h00);
        cyc(0, 1, 1, 1, 8'h00);
        // clock enables low: requests ignored
        cyc(1, 0, 0, 1, 8'h99);
        cyc(0, 1, 1, 0, 8'h00);
        // simultaneous push/pop with one word held
        cyc(1, 1, 0, 1, 8'h11);
        cyc(1, 1, 1, 1, 8'h33);
        cyc(1, 1, 1, 1, 8'h34);
        // fill, then blocked write while full
        cyc(1, 1, 0, 1, 8'h35);
        cyc(1, 1, 0, 1, 8'h44);
        // full: push+pop lets only the pop through
        cyc(1, 1, 1, 1, 8'h45);
        cyc(1, 1, 0, 1, 8'h46);
        // reset while full, then reuse
        do_reset();
        cyc(1, 1, 0, 1, 8'h55);
        cyc(0, 1, 1, 1, 8'h00);
        // blocked read while empty
        cyc(0, 1, 1, 1, 8'h00);
        cyc(1, 1, 1, 1, 8'h66);
        cyc(0, 1, 1, 1, 8'h00);

        // DEPTH=1 instance
        chk("d1_rst_empty_n", 32'(empty_n1), 32'd0);
        chk("d1_rst_full_n", 32'(full_n1), 32'd1);
        wr1 = 1; din1 = 8'hAA;
        @(posedge clk); #1;
        wr1 = 0;
        chk("d1_full_n", 32'(full_n1), 32'd0);
        chk("d1_empty_n", 32'(empty_n1), 32'd1);
        chk("d1_dout", 32'(dout1), 32'hAA);
        wr1 = 1; din1 = 8'hBB;
        #1;
        chk("d1_blocked_we", 32'(we1), 32'd0);
        @(posedge clk); #1;
        wr1 = 0;
        chk("d1_err", 32'(err1), 32'(ERR_EN));
        chk("d1_dout_held", 32'(dout1), 32'hAA);
        rd1 = 1;
        @(posedge clk); #1;
        rd1 = 0;
        chk("d1_pop_full_n", 32'(full_n1), 32'd1);
        chk("d1_pop_empty_n", 32'(empty_n1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
